// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable symbol-sequence detector.
// Watches a qualified DATA_W-bit symbol stream and pulses when the last LEN
// accepted symbols equal the programmed pattern (slot 0 = oldest symbol).
// Keeps a saturating match counter and a sticky match flag.
module seq_detector_param #(
    parameter int DATA_W      = 3,
    parameter int MAX_LEN     = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_LEN = 3,
    parameter logic [MAX_LEN*DATA_W-1:0] DEFAULT_PATTERN =
        (MAX_LEN*DATA_W)'({3'b100, 3'b010, 3'b001}),
    parameter int AW          = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              overlap,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              clear,
    output logic              sequence_found,
    output logic              found_sticky,
    output logic [CNT_W-1:0]  match_count,
    output logic [AW-1:0]     busy_fill
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // history[0] is the newest symbol, history[k] arrived k symbols earlier
    logic [DATA_W-1:0] history [MAX_LEN];
    logic [DATA_W-1:0] shifted [MAX_LEN];
    logic [DATA_W-1:0] pattern [MAX_LEN];

    logic [AW-1:0]     len;
    logic [AW-1:0]     fill;
    logic [AW-1:0]     fill_nxt;
    logic [AW-1:0]     fill_plus;

    logic              accept;
    logic              cfg_slot;
    logic              cfg_len;
    logic              cfg_flush;
    logic              window_eq;
    logic              hit;
    logic              flush;
    logic              shift_en;

    // Decode acceptance and configuration writes; build the shifted window
    always_comb begin
        accept    = enable & data_valid & ~cfg_we;
        cfg_slot  = cfg_we && (int'(cfg_addr) < MAX_LEN);
        cfg_len   = cfg_we && (int'(cfg_addr) == MAX_LEN) && (cfg_data != '0);
        cfg_flush = cfg_slot | cfg_len;
        fill_plus = fill + AW'(1);
        shifted[0] = data;
        for (int k = 1; k < MAX_LEN; k++) begin
            shifted[k] = history[k-1];
        end
    end

    // Compare the window including the incoming symbol against the pattern;
    // pattern slot i lines up with the symbol that arrived len-1-i symbols ago
    always_comb begin
        window_eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                if ((AW'(i) < len) && (AW'(j) == len - AW'(1) - AW'(i)) &&
                    (shifted[j] != pattern[i])) begin
                    window_eq = 1'b0;
                end
            end
        end
        hit = accept && (fill_plus >= len) && window_eq;
    end

    // Next-state logic: disable and config writes flush, matches may flush
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        flush     = 1'b0;
        shift_en  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            flush     = 1'b1;
            fill_nxt  = '0;
        end else if (cfg_flush) begin
            state_nxt = FILL;
            flush     = 1'b1;
            fill_nxt  = '0;
        end else if (hit && !overlap) begin
            state_nxt = FILL;
            flush     = 1'b1;
            fill_nxt  = '0;
        end else if (accept) begin
            shift_en  = 1'b1;
            fill_nxt  = (fill_plus > len) ? len : fill_plus;
            state_nxt = (fill_nxt == len) ? ARMED : FILL;
        end else if (state == IDLE) begin
            state_nxt = FILL;
        end
    end

    // State, fill count and symbol history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            fill  <= '0;
            for (int k = 0; k < MAX_LEN; k++) begin
                history[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            if (flush) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    history[k] <= '0;
                end
            end else if (shift_en) begin
                history <= shifted;
            end
        end
    end

    // Programmable pattern slots and length; length is clamped to MAX_LEN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= AW'(DEFAULT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                pattern[i] <= DEFAULT_PATTERN[i*DATA_W +: DATA_W];
            end
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (cfg_slot && (cfg_addr == AW'(i))) begin
                    pattern[i] <= cfg_data;
                end
            end
            if (cfg_len) begin
                if (int'(cfg_data) > MAX_LEN) begin
                    len <= AW'(MAX_LEN);
                end else begin
                    len <= AW'(cfg_data);
                end
            end
        end
    end

    // Match pulse, saturating counter and sticky flag; clear loses to a same-cycle match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sequence_found <= 1'b0;
            found_sticky   <= 1'b0;
            match_count    <= '0;
        end else begin
            sequence_found <= hit;
            if (clear) begin
                match_count  <= hit ? CNT_W'(1) : '0;
                found_sticky <= hit;
            end else if (hit) begin
                found_sticky <= 1'b1;
                if (match_count != '1) begin
                    match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end

    assign busy_fill = fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: stimulus pushes the expected
// {count, sticky, fill} for each expected match; a monitor pops on every pulse.
module tb_seq_detector_param;

    localparam int DATA_W  = 3;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int AW      = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic              overlap;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              clear;
    logic              sequence_found;
    logic              found_sticky;
    logic [CNT_W-1:0]  match_count;
    logic [AW-1:0]     busy_fill;

    int checks   = 0;
    int failures = 0;

    // expected record: {match_count, found_sticky, busy_fill}
    logic [CNT_W+AW:0] exp_q [$];

    seq_detector_param #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .DEFAULT_LEN(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_valid(data_valid),
        .data(data), .overlap(overlap), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .clear(clear), .sequence_found(sequence_found),
        .found_sticky(found_sticky), .match_count(match_count),
        .busy_fill(busy_fill)
    );

    always #5 clk = ~clk;

    // Monitor: every pulse must correspond to a queued expectation
    always @(negedge clk) begin
        if (reset && sequence_found) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pulse: unexpected sequence_found at %0t (count=%0d sticky=%0d fill=%0d)",
                         $time, match_count, found_sticky, busy_fill);
            end else begin
                logic [CNT_W+AW:0] e;
                e = exp_q.pop_front();
                if ({match_count, found_sticky, busy_fill} !== e) begin
                    failures++;
                    $display("FAIL pulse_state at %0t: got count=%0d sticky=%0d fill=%0d, want count=%0d sticky=%0d fill=%0d",
                             $time, match_count, found_sticky, busy_fill,
                             e[CNT_W+AW:AW+1], e[AW], e[AW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic sym(input logic [DATA_W-1:0] d, input bit exp_hit,
                       input int exp_cnt, input bit exp_sticky,
                       input int exp_fill, input bit clr = 1'b0);
        data       = d;
        data_valid = 1'b1;
        clear      = clr;
        if (exp_hit) exp_q.push_back({CNT_W'(exp_cnt), exp_sticky, AW'(exp_fill)});
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data       = 3'b111;
        clear      = 1'b0;
    endtask

    task automatic gap(input int n);
        data_valid = 1'b0;
        data       = 3'b111;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int addr, input int value);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = DATA_W'(value);
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; data_valid = 1'b0; data = '0;
        overlap = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; clear = 1'b0;
        #12;
        chk("rst_found",  sequence_found, 0);
        chk("rst_sticky", found_sticky, 0);
        chk("rst_count",  match_count, 0);
        chk("rst_fill",   busy_fill, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: default pattern, overlapping
        enable = 1'b1;
        gap(1);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        sym(3'b100, 1, 1, 1, 3);
        gap(1);
        chk("t1_found_one_cycle", sequence_found, 0);
        chk("t1_count",  match_count, 1);
        chk("t1_sticky", found_sticky, 1);
        chk("t1_fill",   busy_fill, 3);

        // 2: pattern 001,001 length 2, overlap then non-overlap
        cfg_write(0, 3'b001);
        cfg_write(1, 3'b001);
        cfg_write(MAX_LEN, 2);
        chk("t2_fill_flushed", busy_fill, 0);
        do_clear();
        chk("t2_clear_count",  match_count, 0);
        chk("t2_clear_sticky", found_sticky, 0);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b001, 1, 1, 1, 2);
        sym(3'b001, 1, 2, 1, 2);
        sym(3'b001, 1, 3, 1, 2);
        chk("t2_ovl_count", match_count, 3);
        do_clear();
        overlap = 1'b0;
        cfg_write(MAX_LEN, 2);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b001, 1, 1, 1, 0);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b001, 1, 2, 1, 0);
        chk("t2_novl_count", match_count, 2);

        // 3: default pattern restored, gaps do not break a match
        cfg_write(0, 3'b001);
        cfg_write(1, 3'b010);
        cfg_write(2, 3'b100);
        cfg_write(MAX_LEN, 3);
        do_clear();
        overlap = 1'b1;
        sym(3'b001, 0, 0, 0, 0);
        gap(2);
        sym(3'b010, 0, 0, 0, 0);
        gap(2);
        sym(3'b100, 1, 1, 1, 3);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b100, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        gap(1);
        chk("t3_count", match_count, 1);

        // 4: config write flushes a partial match
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        cfg_write(2, 3'b100);
        sym(3'b100, 0, 0, 0, 0);
        chk("t4_fill_after_flush", busy_fill, 1);
        chk("t4_count_no_pulse", match_count, 1);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        sym(3'b100, 1, 2, 1, 3);

        // 5: saturation, clear, clear-with-match, length clamp
        overlap = 1'b0;
        do_clear();
        for (int m = 1; m <= 5; m++) begin
            sym(3'b001, 0, 0, 0, 0);
            sym(3'b010, 0, 0, 0, 0);
            sym(3'b100, 1, (m > 3) ? 3 : m, 1, 0);
        end
        chk("t5_saturated", match_count, 3);
        do_clear();
        chk("t5_clear_count",  match_count, 0);
        chk("t5_clear_sticky", found_sticky, 0);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        sym(3'b100, 1, 1, 1, 0, 1'b1);
        chk("t5_clr_hit_count",  match_count, 1);
        chk("t5_clr_hit_sticky", found_sticky, 1);
        overlap = 1'b1;
        cfg_write(MAX_LEN, 7);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        sym(3'b100, 0, 0, 0, 0);
        chk("t5_len4_no_early", match_count, 1);
        sym(3'b000, 1, 2, 1, 4);
        chk("t5_len_clamped_fill", busy_fill, 4);

        // 6: asynchronous reset drops outputs and restores the default pattern
        cfg_write(0, 3'b011);
        cfg_write(1, 3'b101);
        cfg_write(2, 3'b110);
        cfg_write(MAX_LEN, 3);
        sym(3'b011, 0, 0, 0, 0);
        sym(3'b101, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_found",  sequence_found, 0);
        chk("t6_async_sticky", found_sticky, 0);
        chk("t6_async_count",  match_count, 0);
        chk("t6_async_fill",   busy_fill, 0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        gap(1);
        sym(3'b011, 0, 0, 0, 0);
        sym(3'b101, 0, 0, 0, 0);
        sym(3'b110, 0, 0, 0, 0);
        sym(3'b001, 0, 0, 0, 0);
        sym(3'b010, 0, 0, 0, 0);
        sym(3'b100, 1, 1, 1, 3);
        gap(2);
        chk("t6_count", match_count, 1);
        chk("missed_pulses", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
